instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/mips_fetch_pkg.sv | 27 ++
 rtl/next_pc_calc.sv | 44 ++++
 rtl/instr_fetch_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and defaults for the MIPS-style instruction fetch unit.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_JMP = 2'b01,
    PC_JR  = 2'b10,
    PC_SYS = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_BLTZ = 2'b11
  } brtype_e;

  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
  localparam logic [31:0] SYSCALL_VEC_DEF = 32'h0000_0180;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, branch, jump, jump-register, syscall.
module next_pc_calc
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] SYSCALL_VEC = SYSCALL_VEC_DEF
) (
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_idx,
  input  logic [1:0]  pcsrc,
  input  logic [1:0]  brtype,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] next_pc
);

  logic        taken;
  logic [31:0] br_off;

  assign br_off = {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    taken = 1'b0;
    case (brtype)
      BR_BEQ:  taken = (rs_data == rt_data);
      BR_BNE:  taken = (rs_data != rt_data);
      BR_BLTZ: taken = rs_data[31];
      default: taken = 1'b0;
    endcase
  end

  // Unknown select codes fall through to the default arm: plain sequential fetch.
  always_comb begin
    next_pc = pc_plus4;
    case (pcsrc)
      PC_INC:  next_pc = taken ? (pc_plus4 + br_off) : pc_plus4;
      PC_JMP:  next_pc = {pc_plus4[31:28], instr_idx, 2'b00};
      PC_JR:   next_pc = {rs_data[31:2], 2'b00};
      PC_SYS:  next_pc = SYSCALL_VEC;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch FSM (FETCH/ISSUE/HALT) with PC and instruction registers.
// Define SYSCALL_TRAP_EN to vector syscalls to SYSCALL_VEC instead of halting.
module instr_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter logic [31:0] SYSCALL_VEC = SYSCALL_VEC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] Instr,
  output logic [5:0]  Op,
  output logic [5:0]  Func,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic [1:0]  PCSrc,
  input  logic [1:0]  BrType,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Halted
);

  fetch_state_e state, state_n;
  logic [31:0]  pc_q, instr_q, pc_plus4, next_pc;
  logic         req_q, fetch_done, accept;

  assign pc_plus4   = pc_q + 32'd4;
  assign fetch_done = (state == S_FETCH) && req_q && IMemAck;
  assign accept     = (state == S_ISSUE) && InstrReady;

  next_pc_calc #(.SYSCALL_VEC(SYSCALL_VEC)) u_next_pc (
    .pc_plus4  (pc_plus4),
    .instr_idx (instr_q[25:0]),
    .pcsrc     (PCSrc),
    .brtype    (BrType),
    .rs_data   (RsData),
    .rt_data   (RtData),
    .next_pc   (next_pc)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH: if (fetch_done) state_n = S_ISSUE;
      S_ISSUE: begin
        if (InstrReady) begin
          state_n = S_FETCH;
`ifndef SYSCALL_TRAP_EN
          if (PCSrc == PC_SYS) state_n = S_HALT;
`endif
        end
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  // req_q is registered so the request stays low through reset and rises on the first edge after it.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state <= state_n;
      req_q <= (state_n == S_FETCH);
      if (fetch_done) instr_q <= IMemData;
      if (accept && (state_n == S_FETCH)) pc_q <= next_pc;
    end
  end

  assign IMemReq    = req_q;
  assign IMemAddr   = req_q ? pc_q : '0;
  assign Instr      = instr_q;
  assign Op         = instr_q[31:26];
  assign Func       = instr_q[5:0];
  assign InstrValid = (state == S_ISSUE);
  assign PC         = pc_q;
  assign PCPlus4    = pc_plus4;
  assign Halted     = (state == S_HALT);

endmodule
